// File: rtl/accumulate_pkg.sv
// Shared definitions for the accumulate sequencer: default widths and the
// sequencer state encoding.
package accumulate_pkg;

    localparam int unsigned WORD_LENGTH_DEF = 8;
    localparam int unsigned COUNT_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COLLECT,
        DRAIN,
        READ,
        CAPTURE,
        DONE
    } seq_state_e;

endpackage

// File: rtl/accumulate_sequencer_burst_counter.sv
// Burst transfer counter for the accumulate sequencer.
// Ports:
//   clk, n_rst  - clock, synchronous active-low reset
//   i_clear     - synchronous clear of the count
//   i_inc       - count one accepted transfer
//   i_limit     - latched burst length
//   o_done_c    - combinational: the transfer counted this cycle is the last one
module burst_counter
    import accumulate_pkg::*;
#(
    parameter int unsigned Count_Width = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   i_clear,
    input  logic                   i_inc,
    input  logic [Count_Width-1:0] i_limit,
    output logic                   o_done_c
);

    logic [Count_Width-1:0] r_count;
    logic [Count_Width-1:0] w_count_inc;

    assign w_count_inc = r_count + Count_Width'(1);

    // Transfer counter
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_count_inc;
        end
    end

    // Compare the post-increment value so the FSM leaves COLLECT on the last transfer
    assign o_done_c = i_inc && (w_count_inc == i_limit);

endmodule

// File: rtl/accumulate_sequencer.sv
// Upstream controller for the Accumulator stage: clears the Accumulator,
// strobes in a burst of samples, reads back the sum and reports it with a
// sticky overflow flag.
// Ports:
//   clk, n_rst                 - clock, synchronous active-low reset
//   start, sample_count        - burst request and length (latched in IDLE)
//   sample_valid/data/ready    - valid/ready sample source
//   acc_n_rst, acc_enable,
//   acc_read, acc_data_in      - drive the Accumulator
//   acc_data_out               - Accumulator Data_Output
//   result, result_valid       - captured sum and its one-cycle strobe
//   busy, overflow             - not-idle indicator, sticky overflow
module accumulate_sequencer
    import accumulate_pkg::*;
#(
    parameter int unsigned Word_Length = WORD_LENGTH_DEF,
    parameter int unsigned Count_Width = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [Count_Width-1:0] sample_count,
    input  logic                   sample_valid,
    input  logic [Word_Length-1:0] sample_data,
    output logic                   sample_ready,
    output logic                   acc_n_rst,
    output logic                   acc_enable,
    output logic                   acc_read,
    output logic [Word_Length-1:0] acc_data_in,
    input  logic [Word_Length-1:0] acc_data_out,
    output logic [Word_Length-1:0] result,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   overflow
);

    localparam int unsigned SumW = Word_Length + 1;

    seq_state_e             r_state;
    seq_state_e             w_next_state;
    logic [Count_Width-1:0] r_count_lim;
    logic [SumW-1:0]        r_shadow;
    logic [SumW-1:0]        w_shadow_sum;
    logic [SumW-1:0]        w_shadow_next;
    logic                   r_acc_enable;
    logic [Word_Length-1:0] r_acc_data_in;
    logic [Word_Length-1:0] r_result;
    logic                   r_overflow;
    logic                   w_sample_ready;
    logic                   w_clear_pulse;
    logic                   w_acc_read;
    logic                   w_result_valid;
    logic                   w_busy;
    logic                   w_transfer;
    logic                   w_start_accept;
    logic                   w_burst_done;

    assign w_transfer     = sample_valid && w_sample_ready;
    assign w_start_accept = (r_state == IDLE) && start;

    burst_counter #(
        .Count_Width (Count_Width)
    ) u_burst_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_clear  (w_clear_pulse),
        .i_inc    (w_transfer),
        .i_limit  (r_count_lim),
        .o_done_c (w_burst_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = CLEAR;
            CLEAR:   w_next_state = (r_count_lim == '0) ? DRAIN : COLLECT;
            COLLECT: if (w_burst_done) w_next_state = DRAIN;
            DRAIN:   w_next_state = READ;
            READ:    w_next_state = CAPTURE;
            CAPTURE: w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_sample_ready = 1'b0;
        w_clear_pulse  = 1'b0;
        w_acc_read     = 1'b0;
        w_result_valid = 1'b0;
        w_busy         = (r_state != IDLE);
        unique case (r_state)
            CLEAR:   w_clear_pulse  = 1'b1;
            COLLECT: w_sample_ready = 1'b1;
            READ:    w_acc_read     = 1'b1;
            CAPTURE: w_acc_read     = 1'b1;
            DONE:    w_result_valid = 1'b1;
            default: ;
        endcase
    end

    // Shadow sum keeps its top bit sticky so later carries cannot hide an overflow
    assign w_shadow_sum  = r_shadow + SumW'(sample_data);
    assign w_shadow_next = {r_shadow[SumW-1] | w_shadow_sum[SumW-1], w_shadow_sum[SumW-2:0]};

    // Strobe registers, shadow adder, result capture
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count_lim   <= '0;
            r_shadow      <= '0;
            r_acc_enable  <= 1'b0;
            r_acc_data_in <= '0;
            r_result      <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_acc_enable <= w_transfer;
            if (w_start_accept) begin
                r_count_lim <= sample_count;
                r_overflow  <= 1'b0;
            end
            if (w_clear_pulse) begin
                r_shadow <= '0;
            end
            if (w_transfer) begin
                r_acc_data_in <= sample_data;
                r_shadow      <= w_shadow_next;
                r_overflow    <= r_overflow | w_shadow_next[SumW-1];
            end
            if (r_state == CAPTURE) begin
                r_result <= acc_data_out;
            end
        end
    end

    assign sample_ready = w_sample_ready;
    assign acc_n_rst    = n_rst & ~w_clear_pulse;
    assign acc_enable   = r_acc_enable;
    assign acc_read     = w_acc_read;
    assign acc_data_in  = r_acc_data_in;
    assign result       = r_result;
    assign result_valid = w_result_valid;
    assign busy         = w_busy;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_accumulate_sequencer.sv
// Bench for accumulate_sequencer: a stub Accumulator, a valid/ready source with
// optional gaps, and a burst-level reference model (sum, overflow, latency).
module tb_accumulate_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [CW-1:0] sample_count;
    logic          sample_valid;
    logic [W-1:0]  sample_data;
    logic          sample_ready;
    logic          acc_n_rst;
    logic          acc_enable;
    logic          acc_read;
    logic [W-1:0]  acc_data_in;
    logic [W-1:0]  acc_data_out;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          busy;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;
    int data[16];
    int last_result = 0;

    always #5 clk = ~clk;

    accumulate_sequencer #(
        .Word_Length (W),
        .Count_Width (CW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .sample_count (sample_count),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .acc_n_rst    (acc_n_rst),
        .acc_enable   (acc_enable),
        .acc_read     (acc_read),
        .acc_data_in  (acc_data_in),
        .acc_data_out (acc_data_out),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .overflow     (overflow)
    );

    // Accumulator stand-in: sums on enable, registers the sum onto Data_Output on read
    logic [W-1:0] acc_sum;
    logic [W-1:0] acc_q;
    always @(posedge clk) begin
        if (!acc_n_rst) begin
            acc_sum <= '0;
            acc_q   <= '0;
        end else begin
            if (acc_enable) acc_sum <= acc_sum + acc_data_in;
            if (acc_read)   acc_q   <= acc_sum;
        end
    end
    assign acc_data_out = acc_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},   32'(sample_ready), 0);
        chk({tag, "_enable"},  32'(acc_enable),   0);
        chk({tag, "_read"},    32'(acc_read),     0);
        chk({tag, "_data_in"}, 32'(acc_data_in),  0);
        chk({tag, "_result"},  32'(result),       0);
        chk({tag, "_valid"},   32'(result_valid), 0);
        chk({tag, "_busy"},    32'(busy),         0);
        chk({tag, "_ovf"},     32'(overflow),     0);
    endtask

    // One burst of n samples from data[]; the source drops valid for stall_len
    // COLLECT cycles after stall_after transfers.
    task automatic run_burst(input int n, input int stall_after, input int stall_len,
                             input bit inj_start, input string name);
        int  sum, exp_res, eff_stall, d, rdy_last, xfers, gap_left, prev_data;
        bit  exp_ovf, prev_xfer, in_gap, exp_rdy;
        sum = 0;
        for (int i = 0; i < n; i++) sum += data[i];
        exp_res   = sum % 256;
        exp_ovf   = (sum > 255);
        eff_stall = (stall_after < n) ? stall_len : 0;
        d         = (n == 0) ? 5 : n + 5 + eff_stall;
        rdy_last  = n + 1 + eff_stall;
        xfers     = 0;
        gap_left  = eff_stall;
        prev_xfer = 1'b0;
        prev_data = 0;
        for (int c = 0; c <= d; c++) begin
            @(posedge clk); #1;
            in_gap = (c >= 2) && (xfers == stall_after) && (gap_left > 0);
            start  = (c == 0) || (inj_start && c == 3);
            if (c == 0) sample_count = CW'(n);
            else if (inj_start && c == 3) sample_count = CW'((n + 7) % 16);
            sample_valid = !in_gap;
            sample_data  = (xfers < n) ? W'(data[xfers]) : W'($urandom_range(0, 255));
            exp_rdy      = (n > 0) && (c >= 2) && (c <= rdy_last);
            @(negedge clk);
            chk({name, "_ready"},   32'(sample_ready), 32'(exp_rdy));
            chk({name, "_busy"},    32'(busy),         32'(c >= 1));
            chk({name, "_acc_nrst"},32'(acc_n_rst),    32'(c != 1));
            chk({name, "_enable"},  32'(acc_enable),   32'(prev_xfer));
            chk({name, "_read"},    32'(acc_read),     32'(c == d - 2 || c == d - 1));
            chk({name, "_valid"},   32'(result_valid), 32'(c == d));
            if (prev_xfer) chk({name, "_data_in"}, 32'(acc_data_in), 32'(prev_data));
            if (c == 1) chk({name, "_ovf_clr"}, 32'(overflow), 0);
            if (c < d) chk({name, "_hold"}, 32'(result), 32'(last_result));
            if (c == d) begin
                chk({name, "_result"}, 32'(result),   32'(exp_res));
                chk({name, "_ovf"},    32'(overflow), 32'(exp_ovf));
            end
            prev_xfer = exp_rdy && sample_valid;
            prev_data = int'(sample_data);
            if (prev_xfer) xfers++;
            else if (in_gap) gap_left--;
        end
        start       = 1'b0;
        last_result = exp_res;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) data[i] = int'($urandom_range(0, 255));
    endtask

    // Reset asserted for one cycle during COLLECT of a 5-sample burst
    task automatic run_reset_mid_burst();
        fill_random(5);
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1;
            start        = (c == 0);
            sample_count = CW'(5);
            sample_valid = 1'b1;
            sample_data  = W'(data[0]);
            n_rst        = (c != 4);
            @(negedge clk);
            if (c == 3) chk("rst_mid_ready", 32'(sample_ready), 1);
            if (c == 4) chk("rst_mid_acc_nrst", 32'(acc_n_rst), 0);
            if (c == 5) begin
                check_reset_outputs("rst_mid");
                chk("rst_mid_acc_nrst_after", 32'(acc_n_rst), 1);
            end
        end
        start       = 1'b0;
        last_result = 0;
    endtask

    initial begin
        n_rst        = 1'b0;
        start        = 1'b0;
        sample_count = '0;
        sample_valid = 1'b0;
        sample_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_acc_nrst", 32'(acc_n_rst), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        for (int i = 0; i < 3; i++) data[i] = 3;
        run_burst(3, 0, 0, 1'b0, "basic");

        data[0] = 200; data[1] = 100;
        run_burst(2, 0, 0, 1'b0, "ovf");
        data[0] = 5;
        run_burst(1, 0, 0, 1'b0, "ovf_next");

        fill_random(4);
        run_burst(4, 2, 3, 1'b0, "stall");

        run_burst(0, 0, 0, 1'b0, "zero");

        fill_random(6);
        run_burst(6, 0, 0, 1'b1, "ign_start");

        run_reset_mid_burst();
        fill_random(5);
        run_burst(5, 0, 0, 1'b0, "post_rst");

        for (int k = 0; k < 10; k++) begin
            int n;
            n = int'($urandom_range(0, 15));
            fill_random(n);
            run_burst(n, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), "rand");
        end

        fill_random(15);
        for (int i = 0; i < 15; i++) data[i] = 255;
        run_burst(15, 0, 0, 1'b0, "max");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
